// File: rtl/axis_uart_ext.sv
// axis_uart_ext: UART serial engine between AXI-Stream TX/RX FIFOs and the pads.
// Runtime frame format (5..DATA_WIDTH data bits, optional parity, 1/2 stop bits),
// majority-vote oversampled receiver, break detection and RX idle timeout.
module axis_uart_ext #(
    parameter int DATA_WIDTH    = 9,
    parameter int DIVIDER_WIDTH = 16,
    parameter int OVERSAMPLE    = 16,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic [3:0]               data_bits_i,
    input  logic                     stop2_i,
    input  logic                     parity_en_i,
    input  logic                     parity_odd_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
    input  logic                     uart_rx_i,
    output logic                     uart_tx_o,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [2:0]               m_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     break_o,
    output logic                     rx_timeout_o,
    output logic                     tx_busy_o
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] SMP0    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] SMP1    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] SMP2    = OS_W'(OVERSAMPLE / 2 + 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE     = 3'd0;
    localparam logic [2:0] RX_START    = 3'd1;
    localparam logic [2:0] RX_DATA     = 3'd2;
    localparam logic [2:0] RX_PARITY   = 3'd3;
    localparam logic [2:0] RX_STOP     = 3'd4;
    localparam logic [2:0] RX_BRK_WAIT = 3'd5;

    // Clamp the runtime data-bit count into 5..DATA_WIDTH.
    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b < 4'd5)
            return 4'd5;
        else if (int'(b) > DATA_WIDTH)
            return 4'(DATA_WIDTH);
        else
            return b;
    endfunction

    // XOR of the low n bits of d.
    function automatic logic masked_xor(input logic [DATA_WIDTH-1:0] d, input logic [3:0] n);
        logic [DATA_WIDTH-1:0] m;
        m = ~({DATA_WIDTH{1'b1}} << n);
        return ^(d & m);
    endfunction

    // ---------------- baud tick ----------------
    logic [DIVIDER_WIDTH-1:0] tick_cnt;
    logic                     tick;
    assign tick = (tick_cnt == '0);

    // Free-running down-counter, one-cycle tick at zero then reload.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= clk_divider_i;
        else
            tick_cnt <= tick_cnt - 1'b1;
    end

    // ---------------- transmitter ----------------
    logic [2:0]            tx_state;
    logic [OS_W-1:0]       tx_os;
    logic [DATA_WIDTH-1:0] tx_shreg;
    logic [3:0]            tx_bits;
    logic [3:0]            tx_bit;
    logic                  tx_par_en;
    logic                  tx_par;
    logic                  tx_stop2;
    logic                  tx_stop_2nd;
    logic                  tx_line;
    logic                  tx_end;

    assign tx_end        = tick && (tx_os == OS_LAST);
    assign uart_tx_o     = tx_line;
    assign tx_busy_o     = (tx_state != TX_IDLE);
    assign s_axis_tready = (tx_state == TX_IDLE) && !rst_i;

    // TX frame sequencer; the line is registered and updated on each bit boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state    <= TX_IDLE;
            tx_os       <= '0;
            tx_shreg    <= '0;
            tx_bits     <= 4'd5;
            tx_bit      <= '0;
            tx_par_en   <= 1'b0;
            tx_par      <= 1'b0;
            tx_stop2    <= 1'b0;
            tx_stop_2nd <= 1'b0;
            tx_line     <= 1'b1;
        end else begin
            if (tx_state != TX_IDLE && tick)
                tx_os <= tx_end ? '0 : tx_os + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (s_axis_tvalid) begin
                        tx_shreg    <= s_axis_tdata;
                        tx_bits     <= clamp_bits(data_bits_i);
                        tx_bit      <= '0;
                        tx_par_en   <= parity_en_i;
                        tx_par      <= masked_xor(s_axis_tdata, clamp_bits(data_bits_i)) ^ parity_odd_i;
                        tx_stop2    <= stop2_i;
                        tx_stop_2nd <= 1'b0;
                        tx_os       <= '0;
                        tx_line     <= 1'b0;
                        tx_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_end) begin
                        tx_line  <= tx_shreg[0];
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_end) begin
                        if (tx_bit == tx_bits - 4'd1) begin
                            if (tx_par_en) begin
                                tx_line  <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_shreg <= tx_shreg >> 1;
                            tx_line  <= tx_shreg[1];
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_end) begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_end) begin
                        if (tx_stop2 && !tx_stop_2nd)
                            tx_stop_2nd <= 1'b1;
                        else
                            tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic [1:0] rx_sync;
    logic       rx_s;
    assign rx_s = rx_sync[1];

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rx_sync <= 2'b11;
        else
            rx_sync <= {rx_sync[0], uart_rx_i};
    end

    logic [2:0]            rx_state;
    logic [OS_W-1:0]       rx_os;
    logic [1:0]            rx_samp;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [DATA_WIDTH-1:0] rx_mask;
    logic [3:0]            rx_bits;
    logic [3:0]            rx_bit;
    logic                  rx_par_en;
    logic                  rx_par_odd;
    logic                  rx_par_bit;
    logic                  rx_pe;
    logic                  rx_fe;
    logic                  rx_done;
    logic                  brk_pulse;
    logic                  rx_mid;
    logic                  rx_vote;

    assign rx_mid  = tick && (rx_os == SMP2);
    assign rx_vote = (rx_samp[0] & rx_samp[1]) | (rx_samp[0] & rx_s) | (rx_samp[1] & rx_s);

    // RX sequencer. The bit counter runs continuously from the start edge and every
    // decision is taken at the third sample point, so the state names the bit being
    // sampled next and the stop bit returns to IDLE mid-bit for early resync.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state   <= RX_IDLE;
            rx_os      <= '0;
            rx_samp    <= 2'b11;
            rx_data    <= '0;
            rx_mask    <= '0;
            rx_bits    <= 4'd5;
            rx_bit     <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
            rx_pe      <= 1'b0;
            rx_fe      <= 1'b0;
            rx_done    <= 1'b0;
            brk_pulse  <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            brk_pulse <= 1'b0;
            if (rx_state != RX_IDLE && rx_state != RX_BRK_WAIT && tick) begin
                rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + 1'b1;
                if (rx_os == SMP0) rx_samp[0] <= rx_s;
                if (rx_os == SMP1) rx_samp[1] <= rx_s;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_os      <= '0;
                        rx_data    <= '0;
                        rx_mask    <= DATA_WIDTH'(1);
                        rx_bit     <= '0;
                        rx_bits    <= clamp_bits(data_bits_i);
                        rx_par_en  <= parity_en_i;
                        rx_par_odd <= parity_odd_i;
                        rx_par_bit <= 1'b0;
                        rx_pe      <= 1'b0;
                        rx_state   <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_mid)
                        rx_state <= rx_vote ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (rx_mid) begin
                        if (rx_vote)
                            rx_data <= rx_data | rx_mask;
                        rx_mask <= rx_mask << 1;
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == rx_bits - 4'd1)
                            rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (rx_mid) begin
                        rx_par_bit <= rx_vote;
                        rx_pe      <= rx_vote ^ (^rx_data) ^ rx_par_odd;
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_mid) begin
                        if (!rx_vote && rx_data == '0 && !(rx_par_en && rx_par_bit)) begin
                            brk_pulse <= 1'b1;
                            rx_state  <= RX_BRK_WAIT;
                        end else begin
                            rx_fe    <= ~rx_vote;
                            rx_done  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end
                    end
                end
                RX_BRK_WAIT: begin
                    if (rx_s)
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign break_o = brk_pulse;

    // ---------------- output register ----------------
    logic overrun;

    // Holds the received word until accepted; words arriving while blocked set sticky overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            overrun       <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (rx_done) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= rx_data;
                    m_axis_tuser  <= {overrun, rx_fe, rx_pe};
                    m_axis_tvalid <= 1'b1;
                    overrun       <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // ---------------- idle timeout ----------------
    logic                     to_armed;
    logic [OS_W-1:0]          to_os;
    logic [TIMEOUT_WIDTH-1:0] to_cnt;
    logic                     to_pulse;

    assign rx_timeout_o = to_pulse;

    // Counts whole bit times of idle-high line after a completed frame; fires once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_armed <= 1'b0;
            to_os    <= '0;
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else begin
            to_pulse <= 1'b0;
            if (rx_done) begin
                to_armed <= 1'b1;
                to_os    <= '0;
                to_cnt   <= '0;
            end else if (rx_state != RX_IDLE || !rx_s) begin
                to_os  <= '0;
                to_cnt <= '0;
            end else if (to_armed && tick && timeout_i != '0) begin
                if (to_os == OS_LAST) begin
                    to_os <= '0;
                    if (to_cnt == timeout_i - 1'b1) begin
                        to_pulse <= 1'b1;
                        to_armed <= 1'b0;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end else begin
                    to_os <= to_os + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_ext.sv
// Scoreboard bench for axis_uart_ext: directed frames, expected RX words queued
// at stimulus time and popped by an independent monitor on each AXIS handshake.
module tb_axis_uart_ext;

    localparam int DW  = 9;
    localparam int DIVW = 16;
    localparam int OS  = 16;
    localparam int TOW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [DIVW-1:0] clk_divider;
    logic [3:0]      data_bits;
    logic            stop2, parity_en, parity_odd;
    logic [TOW-1:0]  timeout;
    logic            uart_rx, uart_tx;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid, s_tready;
    logic [DW-1:0]   m_tdata;
    logic [2:0]      m_tuser;
    logic            m_tvalid, m_tready;
    logic            brk, rx_to, tx_busy;

    logic loop_en;
    logic rx_drv;
    assign uart_rx = loop_en ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    axis_uart_ext #(
        .DATA_WIDTH(DW), .DIVIDER_WIDTH(DIVW), .OVERSAMPLE(OS), .TIMEOUT_WIDTH(TOW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clk_divider_i(clk_divider), .data_bits_i(data_bits),
        .stop2_i(stop2), .parity_en_i(parity_en), .parity_odd_i(parity_odd),
        .timeout_i(timeout), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .break_o(brk), .rx_timeout_o(rx_to), .tx_busy_o(tx_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int brk_seen = 0;
    int to_seen = 0;
    int to_cyc = 0;
    int pop_cyc = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: counts pulses and checks every accepted RX word against the queue.
    initial forever begin
        logic [11:0] e;
        @(negedge clk);
        if (brk) brk_seen++;
        if (rx_to) begin
            to_seen++;
            to_cyc = cyc;
        end
        if (m_tvalid && m_tready) begin
            pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected got tuser=%b tdata=%0h expected no word", m_tuser, m_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("rx_word{tuser,tdata}", {20'd0, m_tuser, m_tdata}, {20'd0, e});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_bit(input logic b);
        rx_drv = b;
        step(OS);
    endtask

    task automatic send_rx(input logic [8:0] d, input int nbits, input logic pen,
                           input logic pbit, input logic stop_bit);
        rx_bit(1'b0);
        for (int i = 0; i < nbits; i++) rx_bit(d[i]);
        if (pen) rx_bit(pbit);
        rx_bit(stop_bit);
        rx_bit(1'b1);
    endtask

    task automatic wait_sb(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic tx_send(input logic [8:0] d);
        int n;
        n = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        while (!s_tready && n < 2000) begin
            step(1);
            n++;
        end
        chk("tx_ready_wait", {31'd0, s_tready}, 1);
        step(1);
        s_tvalid = 1'b0;
    endtask

    logic [9:0] line_pat;
    int d;

    initial begin
        rst = 1'b1; clk_divider = '0; data_bits = 4'd8; stop2 = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0; timeout = '0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
        loop_en = 1'b0; rx_drv = 1'b1;

        // Reset state
        step(3);
        chk("rst_uart_tx", {31'd0, uart_tx}, 1);
        chk("rst_s_tready", {31'd0, s_tready}, 0);
        chk("rst_m_tvalid", {31'd0, m_tvalid}, 0);
        chk("rst_m_tdata", {23'd0, m_tdata}, 0);
        chk("rst_m_tuser", {29'd0, m_tuser}, 0);
        chk("rst_break", {31'd0, brk}, 0);
        chk("rst_timeout", {31'd0, rx_to}, 0);
        chk("rst_tx_busy", {31'd0, tx_busy}, 0);
        rst = 1'b0;
        step(1);
        chk("post_rst_s_tready", {31'd0, s_tready}, 1);

        // 8N1 0xA5 looped back: line pattern and received word
        loop_en  = 1'b1;
        line_pat = 10'b1101001010;
        exp_q.push_back({3'b000, 9'h0A5});
        tx_send(9'h0A5);
        step(8);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tx_a5_bit%0d", i), {31'd0, uart_tx}, {31'd0, line_pat[i]});
            if (i == 4) chk("tx_busy_mid", {31'd0, tx_busy}, 1);
            if (i < 9) step(OS);
        end
        wait_sb(400);
        step(2 * OS);
        chk("tx_busy_after", {31'd0, tx_busy}, 0);

        // 7E1 0x7F: TX parity bit is 1; looped word has no error
        data_bits = 4'd7; parity_en = 1'b1; parity_odd = 1'b0;
        exp_q.push_back({3'b000, 9'h07F});
        tx_send(9'h07F);
        step(8 + 8 * OS);
        chk("tx_7e1_parity_bit", {31'd0, uart_tx}, 1);
        wait_sb(400);
        step(2 * OS);

        // 7E1 0x7F with forced parity 0 on RX -> parity error
        loop_en = 1'b0; rx_drv = 1'b1;
        exp_q.push_back({3'b001, 9'h07F});
        send_rx(9'h07F, 7, 1'b1, 1'b0, 1'b1);
        wait_sb(200);

        // Framing error: 8N1 with stop bit 0 and non-zero data
        data_bits = 4'd8; parity_en = 1'b0;
        exp_q.push_back({3'b010, 9'h081});
        send_rx(9'h081, 8, 1'b0, 1'b0, 1'b0);
        wait_sb(200);

        // Short glitch: false start, nothing produced, RX still usable
        rx_drv = 1'b0;
        step(4);
        rx_drv = 1'b1;
        step(3 * OS);
        chk("glitch_no_tvalid", {31'd0, m_tvalid}, 0);
        chk("glitch_no_break", brk_seen, 0);
        exp_q.push_back({3'b000, 9'h05A});
        send_rx(9'h05A, 8, 1'b0, 1'b0, 1'b1);
        wait_sb(200);

        // Data-bit clamping: 15 -> 9, 3 -> 5
        data_bits = 4'd15;
        exp_q.push_back({3'b000, 9'h1A5});
        send_rx(9'h1A5, 9, 1'b0, 1'b0, 1'b1);
        wait_sb(200);
        data_bits = 4'd3;
        exp_q.push_back({3'b000, 9'h015});
        send_rx(9'h015, 5, 1'b0, 1'b0, 1'b1);
        wait_sb(200);
        data_bits = 4'd8;

        // Break: 20 bit times low -> one break pulse, no word, then normal frame
        rx_drv = 1'b0;
        step(20 * OS);
        rx_drv = 1'b1;
        step(2 * OS);
        chk("break_pulses", brk_seen, 1);
        exp_q.push_back({3'b000, 9'h03C});
        send_rx(9'h03C, 8, 1'b0, 1'b0, 1'b1);
        wait_sb(200);

        // Overrun: hold 0x11, drop 0x22, flag on next word 0x33
        m_tready = 1'b0;
        exp_q.push_back({3'b000, 9'h011});
        send_rx(9'h011, 8, 1'b0, 1'b0, 1'b1);
        send_rx(9'h022, 8, 1'b0, 1'b0, 1'b1);
        step(OS);
        chk("hold_tvalid", {31'd0, m_tvalid}, 1);
        chk("hold_tdata", {23'd0, m_tdata}, 32'h11);
        chk("hold_tuser", {29'd0, m_tuser}, 0);
        m_tready = 1'b1;
        step(2);
        exp_q.push_back({3'b100, 9'h033});
        send_rx(9'h033, 8, 1'b0, 1'b0, 1'b1);
        wait_sb(200);

        // Idle timeout: never with timeout 0; once, ~4 bit times after a frame with 4
        chk("no_timeout_when_zero", to_seen, 0);
        timeout = 8'd4;
        exp_q.push_back({3'b000, 9'h055});
        send_rx(9'h055, 8, 1'b0, 1'b0, 1'b1);
        step(300);
        chk("timeout_pulses", to_seen, 1);
        d = to_cyc - pop_cyc;
        checks++;
        if (d < 60 || d > 68) begin
            errors++;
            $display("FAIL timeout_delay got %0d cycles expected 60..68", d);
        end
        timeout = '0;

        // Reset in the middle of a TX frame
        tx_send(9'h000);
        step(20);
        chk("midtx_line_low", {31'd0, uart_tx}, 0);
        rst = 1'b1;
        step(1);
        chk("midtx_rst_line_high", {31'd0, uart_tx}, 1);
        chk("midtx_rst_tready", {31'd0, s_tready}, 0);
        chk("midtx_rst_busy", {31'd0, tx_busy}, 0);
        rst = 1'b0;
        step(1);
        chk("midtx_post_tready", {31'd0, s_tready}, 1);
        step(3 * OS);
        chk("midtx_line_stays_high", {31'd0, uart_tx}, 1);
        chk("midtx_no_word", {31'd0, m_tvalid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
